// File: rtl/move_scheduler.sv
// Frame-rate command scheduler: turns the per-frame button vector into game commands
// (edge actions, DAS auto-shift, soft drop, gravity) and serialises them to the move engine.
module move_scheduler #(
    parameter int DAS_DELAY        = 16,
    parameter int DAS_REPEAT       = 6,
    parameter int SOFT_DROP_PERIOD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttons,
    input  logic       buttons_valid,
    input  logic [5:0] gravity_frames,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    input  logic       cmd_done,
    output logic       paused
);

    localparam int DAS_W  = $clog2(DAS_DELAY + 1);
    localparam int SOFT_W = $clog2(SOFT_DROP_PERIOD + 1);

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_LEFT      = 3'd1,
        CMD_RIGHT     = 3'd2,
        CMD_ROT_CW    = 3'd3,
        CMD_ROT_CCW   = 3'd4,
        CMD_SOFT_DOWN = 3'd5,
        CMD_GRAVITY   = 3'd6,
        CMD_HARD_DROP = 3'd7
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // Pending flags are indexed by command code, so bit 0 does not exist.
    function automatic logic [7:1] cmd_onehot(input cmd_t c);
        logic [7:1] oh;
        for (int i = 1; i <= 7; i++) begin
            oh[i] = (c == cmd_t'(i));
        end
        return oh;
    endfunction

    function automatic cmd_t pick_cmd(input logic [7:1] p);
        cmd_t c;
        if      (p[CMD_HARD_DROP]) c = CMD_HARD_DROP;
        else if (p[CMD_ROT_CW])    c = CMD_ROT_CW;
        else if (p[CMD_ROT_CCW])   c = CMD_ROT_CCW;
        else if (p[CMD_LEFT])      c = CMD_LEFT;
        else if (p[CMD_RIGHT])     c = CMD_RIGHT;
        else if (p[CMD_SOFT_DOWN]) c = CMD_SOFT_DOWN;
        else if (p[CMD_GRAVITY])   c = CMD_GRAVITY;
        else                       c = CMD_NONE;
        return c;
    endfunction

    logic [7:0]        prev_buttons;
    logic [7:0]        rise;
    logic              pause_now;
    logic [DAS_W-1:0]  das_cnt,  das_next;
    logic [SOFT_W-1:0] soft_cnt, soft_next;
    logic [5:0]        grav_cnt, grav_next;
    logic [6:0]        grav_limit;
    dir_t              last_dir, dir_next, cur_dir;
    logic              dir_rise;
    logic [7:1]        pending, pending_next, set_req, accept_clear, pause_clear;
    state_t            state, state_next;
    cmd_t              cmd_q, cmd_next;
    logic              accept;

    assign rise       = buttons & ~prev_buttons;
    // The pausing frame itself already suppresses new requests.
    assign pause_now  = paused ^ rise[BTN_START];
    assign grav_limit = (gravity_frames == 6'd0) ? 7'd1 : {1'b0, gravity_frames};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        set_req   = '0;
        das_next  = das_cnt;
        soft_next = soft_cnt;
        grav_next = grav_cnt;
        dir_next  = last_dir;
        cur_dir   = DIR_NONE;
        dir_rise  = 1'b0;

        if (buttons[BTN_LEFT] && !buttons[BTN_RIGHT]) begin
            cur_dir  = DIR_LEFT;
            dir_rise = rise[BTN_LEFT];
        end else if (buttons[BTN_RIGHT] && !buttons[BTN_LEFT]) begin
            cur_dir  = DIR_RIGHT;
            dir_rise = rise[BTN_RIGHT];
        end

        if (buttons_valid && !pause_now) begin
            set_req[CMD_ROT_CW]    = rise[BTN_A];
            set_req[CMD_ROT_CCW]   = rise[BTN_B];
            set_req[CMD_HARD_DROP] = rise[BTN_UP];

            dir_next = cur_dir;
            if (cur_dir == DIR_NONE) begin
                das_next = '0;
            end else if (cur_dir != last_dir || dir_rise) begin
                set_req[(cur_dir == DIR_LEFT) ? CMD_LEFT : CMD_RIGHT] = 1'b1;
                das_next = '0;
            end else if (int'(das_cnt) + 1 == DAS_DELAY) begin
                set_req[(cur_dir == DIR_LEFT) ? CMD_LEFT : CMD_RIGHT] = 1'b1;
                das_next = DAS_W'(DAS_DELAY - DAS_REPEAT);
            end else begin
                das_next = das_cnt + 1'b1;
            end

            if (buttons[BTN_DOWN]) begin
                grav_next = '0;
                if (rise[BTN_DOWN]) begin
                    set_req[CMD_SOFT_DOWN] = 1'b1;
                    soft_next = '0;
                end else if (int'(soft_cnt) + 1 >= SOFT_DROP_PERIOD) begin
                    set_req[CMD_SOFT_DOWN] = 1'b1;
                    soft_next = '0;
                end else begin
                    soft_next = soft_cnt + 1'b1;
                end
            end else begin
                soft_next = '0;
                if ({1'b0, grav_cnt} + 7'd1 >= grav_limit) begin
                    set_req[CMD_GRAVITY] = 1'b1;
                    grav_next = '0;
                end else begin
                    grav_next = grav_cnt + 1'b1;
                end
            end
        end
    end

    // A command already latched into ISSUE survives a pause until it is accepted.
    always_comb begin
        accept_clear = accept ? cmd_onehot(cmd_q) : '0;
        pause_clear  = '0;
        if (buttons_valid && pause_now) begin
            pause_clear = (state == ST_ISSUE) ? ~cmd_onehot(cmd_q) : '1;
        end
        pending_next = (pending & ~(accept_clear | pause_clear)) | set_req;
    end

    always_comb begin
        state_next = state;
        cmd_next   = cmd_q;
        accept     = 1'b0;
        cmd_valid  = 1'b0;
        cmd        = cmd_q;
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    state_next = ST_ISSUE;
                    cmd_next   = pick_cmd(pending);
                end
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT_DONE;
                    cmd_next   = CMD_NONE;
                end
            end
            ST_WAIT_DONE: begin
                if (cmd_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cmd_next   = CMD_NONE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_buttons <= '0;
            paused       <= 1'b0;
            das_cnt      <= '0;
            soft_cnt     <= '0;
            grav_cnt     <= '0;
            last_dir     <= DIR_NONE;
        end else if (buttons_valid) begin
            prev_buttons <= buttons;
            paused       <= pause_now;
            das_cnt      <= das_next;
            soft_cnt     <= soft_next;
            grav_cnt     <= grav_next;
            last_dir     <= dir_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            state   <= ST_IDLE;
            cmd_q   <= CMD_NONE;
        end else begin
            pending <= pending_next;
            state   <= state_next;
            cmd_q   <= cmd_next;
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: directed frames push expected commands,
// a monitor pops and compares on every accepted handshake.
module tb_move_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic [5:0] gravity_frames;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       cmd_done;
    logic       paused;

    logic eng_done;
    logic man_done;
    bit   auto_done;
    assign cmd_done = eng_done | man_done;

    typedef struct {
        logic [2:0] c;
        int         fr;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;
    int   cur_frame;
    int   frame_cnt;

    move_scheduler #(
        .DAS_DELAY       (16),
        .DAS_REPEAT      (6),
        .SOFT_DROP_PERIOD(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .gravity_frames(gravity_frames),
        .cmd_valid     (cmd_valid),
        .cmd           (cmd),
        .cmd_ready     (cmd_ready),
        .cmd_done      (cmd_done),
        .paused        (paused)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic expect_cmd(input logic [2:0] c, input int fr);
        exp_t e;
        e.c  = c;
        e.fr = fr;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        buttons       = b;
        buttons_valid = 1'b1;
        cur_frame     = frame_cnt;
        frame_cnt++;
        @(posedge clk);
        #1;
        buttons_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset         = 1'b1;
        buttons       = 8'h00;
        buttons_valid = 1'b0;
        man_done      = 1'b0;
        tick(2);
        @(negedge clk);
        reset     = 1'b0;
        frame_cnt = 0;
        cur_frame = 0;
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        check(name, sb.size(), 0);
        tick(8);
    endtask

    // Monitor: compares every accepted command and checks ISSUE stability.
    initial begin
        logic       pv;
        logic [2:0] pc;
        exp_t       e;
        pv = 1'b0;
        pc = 3'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    check("hold_valid", cmd_valid, 1);
                    check("hold_cmd", cmd, pc);
                end
                if (!cmd_valid) check("idle_cmd_zero", cmd, 0);
                if (cmd_valid && cmd_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_cmd: actual cmd=%0d frame=%0d, none expected", cmd, cur_frame);
                    end else begin
                        e = sb.pop_front();
                        check("cmd_order", cmd, e.c);
                        if (e.fr >= 0) check("cmd_frame", cur_frame, e.fr);
                    end
                    pv = 1'b0;
                end else begin
                    pv = cmd_valid;
                    pc = cmd;
                end
            end
        end
    end

    // Engine model: raises cmd_done three edges after each accept.
    initial begin
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && cmd_valid && cmd_ready && auto_done) begin
                @(posedge clk);
                repeat (2) @(posedge clk);
                #1 eng_done = 1'b1;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        frame_cnt      = 0;
        cur_frame      = 0;
        reset          = 1'b1;
        buttons        = 8'h00;
        buttons_valid  = 1'b0;
        gravity_frames = 6'd63;
        cmd_ready      = 1'b1;
        man_done       = 1'b0;
        auto_done      = 1'b1;

        // Reset state
        tick(2);
        @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 0);
        check("rst_paused", paused, 0);

        // A for one frame: valid appears after the second edge, then A held yields nothing more
        do_reset();
        cmd_ready = 1'b0;
        expect_cmd(3'd3, 0);
        frame(8'h01, 0);
        @(negedge clk);
        check("t1_valid_edge_k", cmd_valid, 0);
        @(negedge clk);
        check("t1_valid_edge_k1", cmd_valid, 1);
        check("t1_cmd", cmd, 3);
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        tick(8);
        for (int i = 1; i < 10; i++) frame(8'h01, 10);
        frame(8'h00, 10);
        drain("t1_drain");

        // Left held 30 frames: moves at 0, 16, 22, 28
        do_reset();
        expect_cmd(3'd1, 0);
        expect_cmd(3'd1, 16);
        expect_cmd(3'd1, 22);
        expect_cmd(3'd1, 28);
        for (int i = 0; i < 30; i++) frame(8'h40, 10);
        frame(8'h00, 10);
        drain("t2_drain");

        // Up+A+Left together: priority order 7, 3, 1
        do_reset();
        expect_cmd(3'd7, 0);
        expect_cmd(3'd3, 0);
        expect_cmd(3'd1, 0);
        frame(8'h51, 40);
        frame(8'h00, 10);
        drain("t3_drain");

        // gravity_frames=0: gravity each frame; Down held: soft drop every 2nd frame, no gravity
        do_reset();
        gravity_frames = 6'd0;
        for (int i = 0; i < 4; i++) expect_cmd(3'd6, i);
        expect_cmd(3'd5, 4);
        expect_cmd(3'd5, 6);
        expect_cmd(3'd5, 8);
        expect_cmd(3'd6, 10);
        for (int i = 0; i < 4; i++) frame(8'h00, 12);
        for (int i = 0; i < 6; i++) frame(8'h20, 12);
        frame(8'h00, 12);
        drain("t4_drain");
        gravity_frames = 6'd63;

        // Pause while a command waits in ISSUE
        do_reset();
        cmd_ready = 1'b0;
        expect_cmd(3'd3, -1);
        frame(8'h01, 3);
        @(negedge clk);
        check("t5_issue_valid", cmd_valid, 1);
        frame(8'h08, 3);
        @(negedge clk);
        check("t5_paused", paused, 1);
        check("t5_valid_kept", cmd_valid, 1);
        check("t5_cmd_kept", cmd, 3);
        frame(8'h0A, 5);
        frame(8'h40, 5);
        frame(8'h40, 5);
        @(negedge clk);
        check("t5_still_valid", cmd_valid, 1);
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        drain("t5_accept");
        frame(8'h40, 10);
        frame(8'h40, 10);
        frame(8'h01, 10);
        @(negedge clk);
        check("t5_no_cmd_paused", cmd_valid, 0);
        check("t5_paused_held", paused, 1);
        frame(8'h08, 10);
        @(negedge clk);
        check("t5_unpaused", paused, 0);
        expect_cmd(3'd3, 9);
        frame(8'h01, 10);
        frame(8'h00, 10);
        drain("t5_drain");

        // Reset during WAIT_DONE discards everything; stray cmd_done ignored
        do_reset();
        auto_done = 1'b0;
        expect_cmd(3'd3, 0);
        frame(8'h01, 10);
        frame(8'h02, 5);
        frame(8'h0A, 5);
        @(negedge clk);
        check("t6_paused_before", paused, 1);
        check("t6_wait_no_valid", cmd_valid, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_valid", cmd_valid, 0);
        check("t6_rst_cmd", cmd, 0);
        check("t6_rst_paused", paused, 0);
        tick(2);
        @(negedge clk);
        reset     = 1'b0;
        frame_cnt = 0;
        cur_frame = 0;
        pulse_done();
        tick(5);
        @(negedge clk);
        check("t6_no_leftover", cmd_valid, 0);
        frame(8'h00, 10);
        @(negedge clk);
        check("t6_no_cmd_after_frame", cmd_valid, 0);
        expect_cmd(3'd3, 1);
        frame(8'h01, 10);
        expect_cmd(3'd4, 2);
        frame(8'h02, 10);
        @(negedge clk);
        check("t6_blocked_wait", cmd_valid, 0);
        pulse_done();
        tick(6);
        pulse_done();
        auto_done = 1'b1;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
